econet_tx: RTL

Econet transmit PHY. It serialises host-supplied bytes onto the Econet data line as an HDLC-style frame:
- opening flag(s) `01111110`;
- LSB-first data with zero-bit stuffing;
- closing flag;
- return to idle-high.

It sits between the Econet frame/host logic and the line driver. It is the transmit-side counterpart of the Econet receive PHY and shares its clock.

---
 rtl/econet_tx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/econet_tx.sv
// Econet transmit PHY: serialises host bytes into an HDLC-style frame (opening flags,
// LSB-first zero-stuffed data, closing flag) with the line updated on the falling clock edge.
module econet_tx #(
  parameter int unsigned OPEN_FLAGS = 1
) (
  input  logic       econet_clk,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  input  logic       data_last,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       econet_data,
  output logic       econet_drive,
  output logic [2:0] phy_state,
  output logic       busy,
  output logic       underrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    DATA  = 3'd2,
    CLOSE = 3'd3,
    ABORT = 3'd4
  } state_e;

  localparam logic [7:0] FLAG      = 8'h7E;
  localparam logic [3:0] LAST_FLAG = 4'(OPEN_FLAGS - 1);
  localparam logic [3:0] BYTE_DONE = 4'd8;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] flag_cnt_q, flag_cnt_d;
  logic [2:0] ones_q, ones_d;
  logic [7:0] shift_q, shift_d;
  logic       cur_last_q, cur_last_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_last_q, hold_last_d;
  logic       hold_full_q, hold_full_d;
  logic       line_q, line_d;
  logic       drive_q, drive_d;
  logic       underrun_q, underrun_d;
  logic       load;
  logic       accept;

  // Each edge in a non-idle state emits exactly one line bit; bit_cnt_q is the index of the
  // next bit of the current flag/byte, so BYTE_DONE means the edge after the last bit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    flag_cnt_d  = flag_cnt_q;
    ones_d      = ones_q;
    shift_d     = shift_q;
    cur_last_d  = cur_last_q;
    line_d      = 1'b1;
    drive_d     = 1'b1;
    underrun_d  = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      IDLE: begin
        drive_d = 1'b0;
        if (tx_start) begin
          state_d    = OPEN;
          bit_cnt_d  = 4'd0;
          flag_cnt_d = 4'd0;
        end
      end
      OPEN: begin
        if (bit_cnt_q != BYTE_DONE) begin
          line_d    = FLAG[bit_cnt_q[2:0]];
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (flag_cnt_q != LAST_FLAG) begin
          flag_cnt_d = flag_cnt_q + 4'd1;
          line_d     = FLAG[0];
          bit_cnt_d  = 4'd1;
        end else if (hold_full_q) begin
          state_d = DATA;
          load    = 1'b1;
          ones_d  = {2'b00, hold_data_q[0]};
        end else begin
          state_d    = ABORT;
          underrun_d = 1'b1;
          bit_cnt_d  = 4'd1;
        end
      end
      DATA: begin
        if (ones_q == 3'd5) begin
          // Stuffed zero: the bit counter holds so the byte still spans eight data bits.
          line_d = 1'b0;
          ones_d = 3'd0;
        end else if (bit_cnt_q != BYTE_DONE) begin
          line_d    = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          ones_d    = shift_q[0] ? ones_q + 3'd1 : 3'd0;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (cur_last_q) begin
          state_d   = CLOSE;
          line_d    = FLAG[0];
          bit_cnt_d = 4'd1;
        end else if (hold_full_q) begin
          load   = 1'b1;
          ones_d = hold_data_q[0] ? ones_q + 3'd1 : 3'd0;
        end else begin
          state_d    = ABORT;
          underrun_d = 1'b1;
          bit_cnt_d  = 4'd1;
        end
      end
      CLOSE: begin
        if (bit_cnt_q != BYTE_DONE) begin
          line_d    = FLAG[bit_cnt_q[2:0]];
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else begin
          state_d = IDLE;
          drive_d = 1'b0;
        end
      end
      ABORT: begin
        if (bit_cnt_q != BYTE_DONE) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else begin
          state_d = IDLE;
          drive_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        drive_d = 1'b0;
      end
    endcase

    // A load emits bit 0 of the held byte on the same edge it empties the holding register.
    if (load) begin
      line_d     = hold_data_q[0];
      shift_d    = {1'b0, hold_data_q[7:1]};
      cur_last_d = hold_last_q;
      bit_cnt_d  = 4'd1;
    end
  end

  assign accept = data_valid && !hold_full_q;

  always_comb begin
    hold_full_d = (hold_full_q && !load) || accept;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    if (accept) begin
      hold_data_d = data_in;
      hold_last_d = data_last;
    end
  end

  always_ff @(negedge econet_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      flag_cnt_q  <= 4'd0;
      ones_q      <= 3'd0;
      shift_q     <= 8'h00;
      cur_last_q  <= 1'b0;
      hold_data_q <= 8'h00;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      line_q      <= 1'b1;
      drive_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      flag_cnt_q  <= flag_cnt_d;
      ones_q      <= ones_d;
      shift_q     <= shift_d;
      cur_last_q  <= cur_last_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      line_q      <= line_d;
      drive_q     <= drive_d;
      underrun_q  <= underrun_d;
    end
  end

  assign data_ready   = !hold_full_q;
  assign econet_data  = line_q;
  assign econet_drive = drive_q;
  assign phy_state    = state_q;
  assign busy         = (state_q != IDLE);
  assign underrun     = underrun_q;

endmodule
